// File: rtl/cobalt_pkg.sv
// Shared definitions for the collapsing issue queue: default field widths,
// the stored entry layout and the flattened-CDB slice helper.
package cobalt_pkg;

  localparam int DEF_DATAW = 32;
  localparam int DEF_TAGW  = 6;
  localparam int DEF_OPW   = 4;

  typedef struct packed {
    logic [DEF_OPW-1:0]   opcode;
    logic [DEF_TAGW-1:0]  rdtag;
    logic [DEF_TAGW-1:0]  rstag;
    logic [DEF_TAGW-1:0]  rttag;
    logic [DEF_DATAW-1:0] rsdata;
    logic [DEF_DATAW-1:0] rtdata;
    logic                 rsvalid;
    logic                 rtvalid;
    logic                 valid;
  } entry_t;

  // Bus k of a flattened CDB field of per-bus width w starts at this bit.
  function automatic int bus_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/equeue_wakeup.sv
// Operand wake-up: snoops NCDB result buses for one pending source tag and
// returns the operand's next data/valid.
module equeue_wakeup
  import cobalt_pkg::*;
#(
  parameter int NCDB  = 1,
  parameter int TAGW  = DEF_TAGW,
  parameter int DATAW = DEF_DATAW
) (
  input  logic [TAGW-1:0]       tag_i,
  input  logic [DATAW-1:0]      data_i,
  input  logic                  valid_i,
  input  logic [NCDB*TAGW-1:0]  cdb_tag_i,
  input  logic [NCDB*DATAW-1:0] cdb_data_i,
  input  logic [NCDB-1:0]       cdb_valid_i,
  output logic [DATAW-1:0]      data_o,
  output logic                  valid_o
);

  // Scan from the highest bus down so the lowest matching bus wins.
  always_comb begin
    logic hit_s;
    hit_s   = 1'b0;
    data_o  = data_i;
    valid_o = valid_i;
    for (int k = NCDB - 1; k >= 0; k--) begin
      hit_s   = ~valid_i & cdb_valid_i[k] &
                (cdb_tag_i[bus_lsb(k, TAGW) +: TAGW] == tag_i);
      data_o  = hit_s ? cdb_data_i[bus_lsb(k, DATAW) +: DATAW] : data_o;
      valid_o = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/equeue_collapse.sv
// Age-ordered collapsing issue queue (entry 0 oldest). Stored entry widths
// follow cobalt_pkg; width parameters must match the package defaults.
module equeue_collapse
  import cobalt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DATAW = DEF_DATAW,
  parameter int TAGW  = DEF_TAGW,
  parameter int OPW   = DEF_OPW,
  parameter int NCDB  = 1,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int SW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPW-1:0]        dispatch_opcode,
  input  logic [TAGW-1:0]       dispatch_rdtag,
  input  logic [TAGW-1:0]       dispatch_rstag,
  input  logic [TAGW-1:0]       dispatch_rttag,
  input  logic [DATAW-1:0]      dispatch_rsdata,
  input  logic [DATAW-1:0]      dispatch_rtdata,
  input  logic                  dispatch_rsvalid,
  input  logic                  dispatch_rtvalid,
  input  logic                  dispatch_en,
  output logic                  dispatch_ready,
  input  logic [NCDB*TAGW-1:0]  cdb_tag,
  input  logic [NCDB*DATAW-1:0] cdb_data,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic                  flush,
  output logic [OPW-1:0]        issue_opcode,
  output logic [TAGW-1:0]       issue_rdtag,
  output logic [DATAW-1:0]      issue_rsdata,
  output logic [DATAW-1:0]      issue_rtdata,
  output logic                  issue_ready,
  input  logic                  issue_done,
  output logic [CW-1:0]         count,
  output logic                  almost_full
);

  entry_t           e_q [DEPTH];
  entry_t           e_d [DEPTH];
  entry_t           src_s [DEPTH+1];
  entry_t           wk_s [DEPTH+1];
  entry_t           disp_s;
  logic [DATAW-1:0] rs_data_s [DEPTH+1];
  logic [DATAW-1:0] rt_data_s [DEPTH+1];
  logic             rs_valid_s [DEPTH+1];
  logic             rt_valid_s [DEPTH+1];
  logic [DEPTH-1:0] rdy_s;
  logic [DEPTH-1:0] hole_s;
  logic [SW-1:0]    sel_s;
  logic             do_issue_s;
  logic             enq_s;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Dispatch input packaged as the virtual entry above the top slot.
  always_comb begin
    disp_s         = '0;
    disp_s.opcode  = dispatch_opcode;
    disp_s.rdtag   = dispatch_rdtag;
    disp_s.rstag   = dispatch_rstag;
    disp_s.rttag   = dispatch_rttag;
    disp_s.rsdata  = dispatch_rsdata;
    disp_s.rtdata  = dispatch_rtdata;
    disp_s.rsvalid = dispatch_rsvalid;
    disp_s.rtvalid = dispatch_rtvalid;
    disp_s.valid   = 1'b1;
  end

  for (genvar i = 0; i <= DEPTH; i++) begin : g_wk
    if (i < DEPTH) begin : g_q
      assign src_s[i] = e_q[i];
    end else begin : g_d
      assign src_s[i] = disp_s;
    end
    equeue_wakeup #(.NCDB(NCDB), .TAGW(TAGW), .DATAW(DATAW)) u_rs (
      .tag_i(src_s[i].rstag), .data_i(src_s[i].rsdata), .valid_i(src_s[i].rsvalid),
      .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data), .cdb_valid_i(cdb_valid),
      .data_o(rs_data_s[i]), .valid_o(rs_valid_s[i])
    );
    equeue_wakeup #(.NCDB(NCDB), .TAGW(TAGW), .DATAW(DATAW)) u_rt (
      .tag_i(src_s[i].rttag), .data_i(src_s[i].rtdata), .valid_i(src_s[i].rtvalid),
      .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data), .cdb_valid_i(cdb_valid),
      .data_o(rt_data_s[i]), .valid_o(rt_valid_s[i])
    );
  end

  // Woken copies; the dispatch slot never shifts in, it is placed explicitly.
  always_comb begin
    for (int i = 0; i <= DEPTH; i++) begin
      wk_s[i]         = src_s[i];
      wk_s[i].rsdata  = rs_data_s[i];
      wk_s[i].rsvalid = rs_valid_s[i];
      wk_s[i].rtdata  = rt_data_s[i];
      wk_s[i].rtvalid = rt_valid_s[i];
    end
    wk_s[DEPTH].valid = 1'b0;
  end

  // Oldest-first priority select over registered readiness.
  always_comb begin
    sel_s = '0;
    rdy_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_s[i] = e_q[i].valid & e_q[i].rsvalid & e_q[i].rtvalid;
      sel_s    = rdy_s[i] ? SW'(i) : sel_s;
    end
  end

  assign issue_ready    = |rdy_s;
  assign do_issue_s     = issue_done & issue_ready;
  assign dispatch_ready = (count_q < CW'(DEPTH)) | do_issue_s;
  assign enq_s          = dispatch_en & dispatch_ready;

  // Compaction: everything above the first hole drops one slot, then the
  // dispatch lands in the lowest free slot of the compacted queue.
  always_comb begin
    logic gap_s;
    logic placed_s;
    gap_s    = 1'b0;
    placed_s = 1'b0;
    hole_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hole_s[i] = ~e_q[i].valid | (do_issue_s & (sel_s == SW'(i)));
      gap_s     = gap_s | hole_s[i];
      e_d[i]    = gap_s ? wk_s[i+1] : wk_s[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_s && !placed_s && !e_d[i].valid) begin
        e_d[i]       = wk_s[DEPTH];
        e_d[i].valid = 1'b1;
        placed_s     = 1'b1;
      end else begin
        placed_s     = placed_s;
      end
      e_d[i].valid = e_d[i].valid & ~flush;
    end
  end

  // Occupancy next state.
  always_comb begin
    count_d = flush ? '0 : (count_q + CW'(enq_s) - CW'(do_issue_s));
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        e_q[i] <= e_d[i];
      end
      count_q <= count_d;
    end
  end

  assign issue_opcode = e_q[sel_s].opcode;
  assign issue_rdtag  = e_q[sel_s].rdtag;
  assign issue_rsdata = e_q[sel_s].rsdata;
  assign issue_rtdata = e_q[sel_s].rtdata;
  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(DEPTH - 1));

endmodule
